// File: rtl/obj_pkg.sv
// Shared types and constants for the OBJ line scan-out path.
// Contents: line width, packed per-pixel entry, scan FSM state encoding and
// the compare-write replacement rule used by each line bank.
package obj_pkg;

  localparam int unsigned OBJ_LINE_W = 240;
  localparam int unsigned OBJ_X_W    = 8;
  localparam int unsigned OBJ_PAL_W  = 8;
  localparam int unsigned OBJ_PRIO_W = 2;

  // Column count as an x-sized value, for range checks against wr_x / count.
  localparam logic [OBJ_X_W-1:0] OBJ_LINE_END = OBJ_X_W'(OBJ_LINE_W);

  typedef struct packed {
    logic                  opaque;
    logic                  win;
    logic [OBJ_PRIO_W-1:0] prio;
    logic [OBJ_PAL_W-1:0]  pal;
  } obj_px_t;

  localparam int unsigned OBJ_PX_W = $bits(obj_px_t);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } obj_scan_state_t;

  // Lower prio value wins; on a tie the stored (earlier OAM) pixel is kept.
  function automatic logic obj_replace(input logic                  cur_opaque,
                                       input logic [OBJ_PRIO_W-1:0] cur_prio,
                                       input logic [OBJ_PRIO_W-1:0] new_prio);
    return !cur_opaque || (new_prio < cur_prio);
  endfunction

endpackage

// File: rtl/obj_line_bank.sv
// One OBJ line bank: OBJ_LINE_W entries with a priority compare-write port
// and a read-and-clear port.
// Ports:
//   clock, reset          - clock, synchronous active-high reset (clears all entries)
//   wr_en/wr_x/wr_pal/wr_prio/wr_window - renderer write; x >= OBJ_LINE_W is dropped
//   rd_en, rd_x           - clear entry rd_x at the next edge
//   rd_data_c             - combinational contents of entry rd_x
// Build option: OBJ_WINDOW_EN enables storage of the OBJ-window bit; when it
// is undefined window writes are dropped and win stays 0.
module obj_line_bank
  import obj_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [OBJ_X_W-1:0]    wr_x,
  input  logic [OBJ_PAL_W-1:0]  wr_pal,
  input  logic [OBJ_PRIO_W-1:0] wr_prio,
  input  logic                  wr_window,
  input  logic                  rd_en,
  input  logic [OBJ_X_W-1:0]    rd_x,
  output logic [OBJ_PX_W-1:0]   rd_data_c
);

  obj_px_t mem_q [OBJ_LINE_W];
  obj_px_t mem_d [OBJ_LINE_W];

  // Next-state of the array: clear on read, then apply the compare-write.
  always_comb begin
    mem_d = mem_q;
    if (rd_en && (rd_x < OBJ_LINE_END)) begin
      mem_d[rd_x] = '0;
    end
    if (wr_en && (wr_x < OBJ_LINE_END)) begin
`ifdef OBJ_WINDOW_EN
      if (wr_window) begin
        mem_d[wr_x].win = 1'b1;
      end else if (obj_replace(mem_q[wr_x].opaque, mem_q[wr_x].prio, wr_prio)) begin
        mem_d[wr_x].opaque = 1'b1;
        mem_d[wr_x].prio   = wr_prio;
        mem_d[wr_x].pal    = wr_pal;
      end
`else
      if (!wr_window && obj_replace(mem_q[wr_x].opaque, mem_q[wr_x].prio, wr_prio)) begin
        mem_d[wr_x].opaque = 1'b1;
        mem_d[wr_x].prio   = wr_prio;
        mem_d[wr_x].pal    = wr_pal;
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data_c = (rd_x < OBJ_LINE_END) ? mem_q[rd_x] : '0;

endmodule

// File: rtl/obj_line_scanout.sv
// Ping-pong OBJ line buffer: renderer writes line N+1 into the render bank
// while line N is streamed from the display bank over valid/ready, each entry
// cleared as it is read so the bank is blank when it next becomes render bank.
// Ports:
//   clock, reset       - clock, synchronous active-high reset
//   line_start         - swap banks and start scan-out (ignored while scanning)
//   wr_*               - renderer pixel write into the render bank
//   px_valid/px_ready  - scan-out handshake; px_opaque/pal/prio/window payload
//   line_done          - pulse after the last pixel is accepted
//   overrun            - pulse when line_start arrives during a scan
//   busy               - high while scanning
// Build option: OBJ_WINDOW_EN enables the OBJ-window bit (px_window is 0 otherwise).
module obj_line_scanout
  import obj_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       line_start,
  input  logic       wr_en,
  input  logic [7:0] wr_x,
  input  logic [7:0] wr_pal,
  input  logic [1:0] wr_prio,
  input  logic       wr_window,
  output logic       px_valid,
  input  logic       px_ready,
  output logic       px_opaque,
  output logic [7:0] px_pal,
  output logic [1:0] px_prio,
  output logic       px_window,
  output logic       line_done,
  output logic       overrun,
  output logic       busy
);

  obj_scan_state_t      state_q, state_d;
  logic                 bank_sel_q, bank_sel_d;
  logic [OBJ_X_W-1:0]   count_q, count_d;
  obj_px_t              px_q, px_d;
  logic                 px_valid_q, px_valid_d;
  logic                 line_done_q, line_done_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;

  logic                 swap_c;
  logic                 adv_c;
  logic                 rd_en_c;
  logic [OBJ_X_W-1:0]   rd_x_c;
  logic                 wr_en0_c, wr_en1_c;
  logic                 rd_en0_c, rd_en1_c;
  logic [OBJ_PX_W-1:0]  rd_data0_c, rd_data1_c;
  obj_px_t              rd_data_c;

  // Bank steering uses the post-swap select, so a write coinciding with an
  // accepted line_start lands in the freshly drained (new render) bank.
  always_comb begin
    swap_c     = (state_q == IDLE) && line_start;
    adv_c      = (state_q == SCAN) && px_valid_q && px_ready && (count_q < OBJ_LINE_END);
    bank_sel_d = bank_sel_q ^ swap_c;
    rd_en_c    = swap_c || adv_c;
    rd_x_c     = swap_c ? '0 : count_q;
    wr_en0_c   = wr_en && !bank_sel_d;
    wr_en1_c   = wr_en && bank_sel_d;
    rd_en0_c   = rd_en_c && bank_sel_d;
    rd_en1_c   = rd_en_c && !bank_sel_d;
    rd_data_c  = bank_sel_d ? obj_px_t'(rd_data0_c) : obj_px_t'(rd_data1_c);
  end

  // Scan FSM next-state and output-register loads.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    px_d        = px_q;
    px_valid_d  = px_valid_q;
    line_done_d = 1'b0;
    overrun_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (swap_c) begin
          px_d       = rd_data_c;
          px_valid_d = 1'b1;
          count_d    = OBJ_X_W'(1);
          state_d    = SCAN;
        end
      end
      SCAN: begin
        overrun_d = line_start;
        if (adv_c) begin
          px_d    = rd_data_c;
          count_d = count_q + OBJ_X_W'(1);
        end else if (px_valid_q && px_ready) begin
          px_d        = '0;
          px_valid_d  = 1'b0;
          count_d     = '0;
          line_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
    endcase
`ifndef OBJ_WINDOW_EN
    px_d.win = 1'b0;
`endif
    busy_d = (state_d == SCAN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      bank_sel_q  <= 1'b0;
      count_q     <= '0;
      px_q        <= '0;
      px_valid_q  <= 1'b0;
      line_done_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_sel_q  <= bank_sel_d;
      count_q     <= count_d;
      px_q        <= px_d;
      px_valid_q  <= px_valid_d;
      line_done_q <= line_done_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  obj_line_bank u_bank0 (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en0_c),
    .wr_x      (wr_x),
    .wr_pal    (wr_pal),
    .wr_prio   (wr_prio),
    .wr_window (wr_window),
    .rd_en     (rd_en0_c),
    .rd_x      (rd_x_c),
    .rd_data_c (rd_data0_c)
  );

  obj_line_bank u_bank1 (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en1_c),
    .wr_x      (wr_x),
    .wr_pal    (wr_pal),
    .wr_prio   (wr_prio),
    .wr_window (wr_window),
    .rd_en     (rd_en1_c),
    .rd_x      (rd_x_c),
    .rd_data_c (rd_data1_c)
  );

  assign px_valid  = px_valid_q;
  assign px_opaque = px_q.opaque;
  assign px_pal    = px_q.pal;
  assign px_prio   = px_q.prio;
  assign px_window = px_q.win;
  assign line_done = line_done_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule
